// File: rtl/vga_timing_pkg.sv
// Shared mode constants and helpers for the VGA raster timing generator.
// Standard progressive modes are grouped per axis as ACTIVE/FP/SYNC/BP plus sync polarity.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        bit          pol;
    } vga_axis_t;

    // Bit positions inside the delayed control bundle
    localparam int SYNC_W    = 6;
    localparam int SB_HS     = 5;
    localparam int SB_VS     = 4;
    localparam int SB_BLANK  = 3;
    localparam int SB_DE     = 2;
    localparam int SB_LS     = 1;
    localparam int SB_FS     = 0;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned axis_total(input vga_axis_t a);
        return vga_total(a.active, a.fp, a.sync, a.bp);
    endfunction

    // 640x480@60, 25.175 MHz, negative syncs
    localparam vga_axis_t VGA_640X480_H  = '{active: 640,  fp: 16, sync: 96,  bp: 48,  pol: 1'b0};
    localparam vga_axis_t VGA_640X480_V  = '{active: 480,  fp: 10, sync: 2,   bp: 33,  pol: 1'b0};

    // 800x600@60, 40 MHz, positive syncs
    localparam vga_axis_t VGA_800X600_H  = '{active: 800,  fp: 40, sync: 128, bp: 88,  pol: 1'b1};
    localparam vga_axis_t VGA_800X600_V  = '{active: 600,  fp: 1,  sync: 4,   bp: 23,  pol: 1'b1};

    // 1024x768@60, 65 MHz, negative syncs
    localparam vga_axis_t VGA_1024X768_H = '{active: 1024, fp: 24, sync: 136, bp: 160, pol: 1'b0};
    localparam vga_axis_t VGA_1024X768_V = '{active: 768,  fp: 3,  sync: 6,   bp: 29,  pol: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register of DEPTH stages; every stage resets to RST_VAL so the
// outputs show the inactive bundle until real samples have propagated through.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int             W       = SYNC_W,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         pixel_clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] shift_q [DEPTH];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                shift_q[i] <= RST_VAL;
            end
        end else if (en_i) begin
            shift_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

    assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: undelayed h/v counters plus sync/blank/strobes delayed LATENCY cycles.
// Optional frame counter output is built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int          CW       = 11,
    parameter int          LATENCY  = 1
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [CW-1:0] hcount_o,
    output logic [CW-1:0] vcount_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          blank_o,
    output logic          de_o,
    output logic          line_start_o,
    output logic          frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt_o
`endif
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("vga_timing_gen: LATENCY out of range");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_E  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_E  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_B = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_B = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [SYNC_W-1:0] SYNC_RST = {~HS_POL, ~VS_POL, 1'b1, 1'b0, 1'b0, 1'b0};

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          h_wrap, v_wrap;

    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en_i) begin
            hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + CW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;

    // Stage-0 decode; v_sync comes straight from vcount so it switches at hcount==0
    logic h_act, v_act, h_sync, v_sync, blank0, hs0, vs0;
    logic [SYNC_W-1:0] stage0, stage_q;

    assign h_act  = (hcount_q < H_ACT_E);
    assign v_act  = (vcount_q < V_ACT_E);
    assign h_sync = (hcount_q >= H_SYNC_B) && (hcount_q < H_SYNC_E);
    assign v_sync = (vcount_q >= V_SYNC_B) && (vcount_q < V_SYNC_E);
    assign blank0 = ~(h_act && v_act);
    assign hs0    = h_sync ? HS_POL : ~HS_POL;
    assign vs0    = v_sync ? VS_POL : ~VS_POL;

    always_comb begin
        stage0           = SYNC_RST;
        stage0[SB_HS]    = hs0;
        stage0[SB_VS]    = vs0;
        stage0[SB_BLANK] = blank0;
        stage0[SB_DE]    = ~blank0;
        stage0[SB_LS]    = (hcount_q == '0);
        stage0[SB_FS]    = (hcount_q == '0) && (vcount_q == '0);
    end

    vga_sync_delay #(
        .W       (SYNC_W),
        .DEPTH   (LATENCY),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .en_i      (en_i),
        .d_i       (stage0),
        .q_o       (stage_q)
    );

    assign hs_o          = stage_q[SB_HS];
    assign vs_o          = stage_q[SB_VS];
    assign blank_o       = stage_q[SB_BLANK];
    assign de_o          = stage_q[SB_DE];
    assign line_start_o  = stage_q[SB_LS];
    assign frame_start_o = stage_q[SB_FS];

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Count is committed on the edge that retires the pulse; the adder makes the
    // new value visible while the pulse itself is on the output.
    logic [15:0] frame_cnt_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (en_i && frame_start_o) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q + {15'd0, frame_start_o};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two small custom modes (latency 1 / 4, both polarities) and the default 640x480 mode.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsy, ht;
        int va, vfp, vsy, vt;
        int lat;
        bit hp, vp;
    } mode_t;

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instance A: 15x8 raster, active-low syncs, latency 1
    logic rst_a, en_a;
    logic [3:0] hc_a, vc_a;
    logic hs_a, vs_a, blank_a, de_a, ls_a, fs_a;
    // Instance B: same raster, active-high syncs, latency 4
    logic rst_b, en_b;
    logic [4:0] hc_b, vc_b;
    logic hs_b, vs_b, blank_b, de_b, ls_b, fs_b;
    // Instance C: default 640x480 mode
    logic rst_c, en_c;
    logic [10:0] hc_c, vc_c;
    logic hs_c, vs_c, blank_c, de_c, ls_c, fs_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fcnt_a, fcnt_b, fcnt_c;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .LATENCY(1)
    ) u_a (
        .pixel_clk(pixel_clk), .rst(rst_a), .en_i(en_a),
        .hcount_o(hc_a), .vcount_o(vc_a), .hs_o(hs_a), .vs_o(vs_a),
        .blank_o(blank_a), .de_o(de_a), .line_start_o(ls_a), .frame_start_o(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt_o(fcnt_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .LATENCY(4)
    ) u_b (
        .pixel_clk(pixel_clk), .rst(rst_b), .en_i(en_b),
        .hcount_o(hc_b), .vcount_o(vc_b), .hs_o(hs_b), .vs_o(vs_b),
        .blank_o(blank_b), .de_o(de_b), .line_start_o(ls_b), .frame_start_o(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt_o(fcnt_b)
`endif
    );

    vga_timing_gen u_c (
        .pixel_clk(pixel_clk), .rst(rst_c), .en_i(en_c),
        .hcount_o(hc_c), .vcount_o(vc_c), .hs_o(hs_c), .vs_o(vs_c),
        .blank_o(blank_c), .de_o(de_c), .line_start_o(ls_c), .frame_start_o(fs_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt_o(fcnt_c)
`endif
    );

    mode_t ma, mb, mc;
    int na, nb, nc;   // enabled edges since last reset, per instance

    // Expected {hs,vs,blank,de,ls,fs} after n enabled edges
    function automatic logic [5:0] exp_bundle(input mode_t m, input int n);
        int k, h, v;
        logic hsy, vsy, blk;
        if (n < m.lat) return {~m.hp, ~m.vp, 4'b1000};
        k   = n - m.lat;
        h   = k % m.ht;
        v   = (k / m.ht) % m.vt;
        hsy = (h >= m.ha + m.hfp) && (h < m.ha + m.hfp + m.hsy);
        vsy = (v >= m.va + m.vfp) && (v < m.va + m.vfp + m.vsy);
        blk = !((h < m.ha) && (v < m.va));
        return {hsy ? m.hp : ~m.hp, vsy ? m.vp : ~m.vp, blk, ~blk, h == 0, (h == 0) && (v == 0)};
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        if (rst_a) na = 0; else if (en_a) na++;
        if (rst_b) nb = 0; else if (en_b) nb++;
        if (rst_c) nc = 0; else if (en_c) nc++;
        #1;
        check_eq("A_hcount", 32'(hc_a), 32'(na % ma.ht));
        check_eq("A_vcount", 32'(vc_a), 32'((na / ma.ht) % ma.vt));
        check_eq("A_outs", {hs_a, vs_a, blank_a, de_a, ls_a, fs_a}, exp_bundle(ma, na));
        check_eq("B_hcount", 32'(hc_b), 32'(nb % mb.ht));
        check_eq("B_vcount", 32'(vc_b), 32'((nb / mb.ht) % mb.vt));
        check_eq("B_outs", {hs_b, vs_b, blank_b, de_b, ls_b, fs_b}, exp_bundle(mb, nb));
        check_eq("C_hcount", 32'(hc_c), 32'(nc % mc.ht));
        check_eq("C_vcount", 32'(vc_c), 32'((nc / mc.ht) % mc.vt));
        check_eq("C_outs", {hs_c, vs_c, blank_c, de_c, ls_c, fs_c}, exp_bundle(mc, nc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int fs_cnt_a, vs_low_a, hs_low_a, first_hs_b, first_hs_c, hs_low_c, hmax_c;
    int cnt, found;

    initial begin
        ma = '{8, 2, 3, 15, 4, 1, 2, 8, 1, 1'b0, 1'b0};
        mb = '{8, 2, 3, 15, 4, 1, 2, 8, 4, 1'b1, 1'b1};
        mc = '{640, 16, 96, 800, 480, 10, 2, 525, 1, 1'b0, 1'b0};
        na = 0; nb = 0; nc = 0;
        fs_cnt_a = 0; vs_low_a = 0; hs_low_a = 0;
        first_hs_b = -1; first_hs_c = -1; hs_low_c = 0; hmax_c = 0;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b0;  en_b = 1'b0;  en_c = 1'b0;
        tick();
        tick();
        check_eq("A_rst_hs", hs_a, 1'b1);
        check_eq("A_rst_vs", vs_a, 1'b1);
        check_eq("A_rst_blank", blank_a, 1'b1);
        check_eq("A_rst_de", de_a, 1'b0);
        check_eq("A_rst_strobes", {ls_a, fs_a}, 2'b00);
        check_eq("B_rst_syncs", {hs_b, vs_b}, 2'b00);
        check_eq("B_rst_blank", blank_b, 1'b1);
        check_eq("C_rst_hcount", 32'(hc_c), 0);

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            tick();
            if (na >= 1 && na <= 240 && fs_a) fs_cnt_a++;
            if (na >= 1 && na <= 120 && !vs_a) vs_low_a++;
            if (na >= 1 && na <= 120 && !hs_a) hs_low_a++;
            if (na == 1) begin
                check_eq("A_first_blank", blank_a, 1'b0);
                check_eq("A_first_strobes", {ls_a, fs_a}, 2'b11);
            end
            if (nb == 3) check_eq("B_blank_n3", blank_b, 1'b1);
            if (nb == 4) begin
                check_eq("B_blank_n4", blank_b, 1'b0);
                check_eq("B_fs_n4", fs_b, 1'b1);
            end
            if (hs_b && first_hs_b < 0) first_hs_b = nb;
            if (!hs_c && first_hs_c < 0) first_hs_c = nc;
            if (nc >= 1 && nc <= 800 && !hs_c) hs_low_c++;
            if (int'(hc_c) > hmax_c) hmax_c = int'(hc_c);
            if (nc == 800) check_eq("C_vcount_line1", 32'(vc_c), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (na == 241) check_eq("A_frame_cnt_3", 32'(fcnt_a), 3);
`endif
        end
        check_eq("A_frames_in_240", fs_cnt_a, 2);
        check_eq("A_vs_low_cycles", vs_low_a, 30);
        check_eq("A_hs_low_cycles", hs_low_a, 24);
        check_eq("B_hs_first_high", first_hs_b, 14);
        check_eq("C_hs_first_low", first_hs_c, 657);
        check_eq("C_hs_low_per_line", hs_low_c, 96);
        check_eq("C_hcount_max", hmax_c, 799);

        // Freeze A mid-sync for 37 cycles
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (hc_a == 4'd11) found = 1; else tick();
        end
        check_eq("A_reach_h11", found, 1);
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            check_eq("A_freeze_hcount", 32'(hc_a), 11);
            check_eq("A_freeze_hs_blank", {hs_a, blank_a, de_a, ls_a}, 4'b0100);
        end
        en_a = 1'b1;
        cnt = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(); cnt++;
            if (ls_a) found = 1;
        end
        check_eq("A_cycles_to_ls_after_freeze", cnt, 5);
        cnt = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(); cnt++;
            if (ls_a) found = 1;
        end
        check_eq("A_line_length", cnt, 15);

        // Mid-frame reset: A with en high, B with en low
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (hc_a == 4'd3 && vc_a == 4'd2) found = 1; else tick();
        end
        check_eq("A_reach_h3_v2", found, 1);
        rst_a = 1'b1; rst_b = 1'b1; en_b = 1'b0;
        tick();
        check_eq("A_midrst_counts", {hc_a, vc_a}, 8'h00);
        check_eq("A_midrst_hs_blank", {hs_a, blank_a, fs_a}, 3'b110);
        check_eq("B_midrst_hcount", 32'(hc_b), 0);
        check_eq("B_midrst_hs_blank", {hs_b, blank_b}, 2'b01);
        rst_a = 1'b0; rst_b = 1'b0; en_b = 1'b1;
        tick();
        check_eq("A_resume_fs", {fs_a, ls_a, blank_a}, 3'b110);
        tick();
        tick();
        check_eq("B_resume_blank_n3", blank_b, 1'b1);
        tick();
        check_eq("B_resume_fs_n4", fs_b, 1'b1);

        repeat (20) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
